wb_mem_slave: RTL and testbench
===============================

# wb_mem_slave

Wishbone-style memory slave that sits directly downstream of the `cpu` core's bus master port and answers its `STB_O`/`WE_O`/`ADR_O`/`DAT_O` requests. It returns read data on `DAT_O`/`INSTR_O` with a single-cycle `AKN_O` after a programmable number of wait states. It is used as the DUT-side memory in the CPU testbench and as the on-chip RAM in the system build. It serves one request at a time; there is no pipelining of requests.

## Interface
Parameters:
- `DATA_W`, default 32: data and instruction word width.
- `ADDR_W`, default 32: byte-address width.
- `DEPTH`, default 1024: number of words; must be a power of two.
- `WAIT_CYCLES`, default 2: wait states inserted between accept and acknowledge; range 0..15.

Ports:
- `CLK_I` in 1: clock, rising edge.
- `RST_I` in 1: asynchronous, active-low reset.
- `STB_I` in 1: request strobe from the CPU `STB_O`.
- `WE_I` in 1: 1 = write, 0 = read.
- `ADR_I` in `ADDR_W`: byte address.
- `DAT_I` in `DATA_W`: write data.
- `AKN_O` out 1: acknowledge, one-cycle pulse.
- `DAT_O` out `DATA_W`: read data, valid while `AKN_O`=1.
- `INSTR_O` out `DATA_W`: the same read word, driven to the CPU `INSTR_I`.
- `BUSY_O` out 1: a request is in flight (states WAIT and RESP).
- `ERR_O` out 1: error pulse. Present only with `WB_MEM_RANGE_CHECK_EN`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `STB_I`=1 at a rising edge, the block latches `ADR_I`, `WE_I` and `DAT_I`.
  - The wait counter is loaded with `WAIT_CYCLES`.
  - Next state is WAIT, or RESP directly when `WAIT_CYCLES`=0.
- WAIT: the counter decrements each cycle. When the counter is 1, the next state is RESP.
- RESP:
  - `AKN_O`=1 for exactly one cycle.
  - For a read, `DAT_O` and `INSTR_O` carry `mem[idx]`.
  - For a write, `mem[idx]` is updated at the rising edge that leaves RESP. `DAT_O` and `INSTR_O` hold their previous values.
  - Next state is always IDLE.
- Word index: `idx = ADR_I[$clog2(DEPTH)+1:2]`. `ADR_I[1:0]` is ignored; misaligned addresses are word-aligned silently.
- Out-of-range addresses (upper bits nonzero) wrap modulo `DEPTH` unless the range check is compiled in.
- `STB_I`, `WE_I`, `ADR_I` and `DAT_I` are ignored in WAIT and RESP; changes during a transfer have no effect.
- A master that still holds `STB_I`=1 in the cycle after `AKN_O` starts a new transfer. This is legal back-to-back operation.
- Memory contents are not reset and power up as X. The bench preloads them via `$readmemh` on the array instance.

## Timing
- Request accepted at edge N; `AKN_O` high during cycle N+1+`WAIT_CYCLES`.
  - Read latency is `WAIT_CYCLES`+1.
  - Minimum back-to-back period is `WAIT_CYCLES`+2 cycles.
- `DAT_O` and `INSTR_O` are registered. They update at the edge entering RESP and hold until the next read's RESP.
- Reset values: state IDLE, `AKN_O`=0, `DAT_O`=0, `INSTR_O`=0, `BUSY_O`=0, `ERR_O`=0, counter 0.
- Reset asserted mid-transfer aborts it:
  - No `AKN_O`.
  - A pending write is not performed.
  - Memory keeps its contents.
- After reset release, the first rising edge with `STB_I`=1 is accepted.

## Configuration
- `WB_MEM_RANGE_CHECK_EN` defined:
  - `ERR_O` exists.
  - An address with any bit above `$clog2(DEPTH)+1` set completes normally through WAIT, but RESP drives `ERR_O`=1 instead of `AKN_O`.
  - On a range error, writes are dropped and `DAT_O`/`INSTR_O` are not updated.
- `WB_MEM_RANGE_CHECK_EN` undefined: there is no `ERR_O` port, and all addresses wrap modulo `DEPTH`.

## Structure
- Package `wb_mem_pkg` holds:
  - the `wb_mem_state_e` enum (IDLE, WAIT, RESP);
  - the defaults `WB_MEM_DATA_W`, `WB_MEM_DEPTH` and `WB_MEM_WAIT_CYCLES`;
  - the `wb_mem_idx()` address-to-index function.
- Sub-module `wb_mem_array` is the storage only: synchronous write, read data registered on an enable, and a `$readmemh`-friendly array.
- The FSM, counter and handshake live in `wb_mem_slave`.

## Test plan
- Back-to-back write/read with `WAIT_CYCLES`=2: write 0xDEADBEEF to 0x10, then read 0x10. Required response:
  - write `AKN_O` at accept+3 cycles;
  - read returns 0xDEADBEEF on `DAT_O` and `INSTR_O` with `AKN_O` at accept+3.
- `WAIT_CYCLES`=0: reads from preloaded words 0..3 with `STB_I` held high continuously. Required response: `AKN_O` every second cycle with data mem[0..3] in order.
- Misalignment: write 0x12345678 to 0x22, then read 0x20. Required response: the read returns 0x12345678.
- Reset mid-transfer: write 0xAAAA5555 to 0x40 (previously 0), then drop `RST_I` during WAIT. Required response:
  - no `AKN_O`, and `BUSY_O` goes to 0 immediately;
  - a later read of 0x40 returns 0.
- Range check, with `DEPTH`=1024 and `WB_MEM_RANGE_CHECK_EN` defined: read 0x1000. Required response: `ERR_O` pulse, no `AKN_O`, `DAT_O` unchanged. Without the macro, the same read returns mem[0].

Source files
------------

// File: rtl/wb_mem_pkg.sv
// Shared types, defaults and address helper for the Wishbone memory slave.
package wb_mem_pkg;
  localparam int WB_MEM_DATA_W      = 32;
  localparam int WB_MEM_DEPTH       = 1024;
  localparam int WB_MEM_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_mem_state_e;

  // Byte address -> word index; the two byte-offset bits are dropped, upper bits wrap.
  function automatic logic [31:0] wb_mem_idx(input logic [63:0] adr, input int unsigned idx_w);
    return 32'((adr >> 2) & ((64'd1 << idx_w) - 64'd1));
  endfunction
endpackage

// File: rtl/wb_mem_array.sv
// Word storage: synchronous write, registered read on enable. Array `mem` is not reset.
module wb_mem_array
  import wb_mem_pkg::*;
#(
  parameter int DATA_W = WB_MEM_DATA_W,
  parameter int DEPTH  = WB_MEM_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/wb_mem_slave.sv
// Single-outstanding Wishbone memory slave with programmable wait states.
// Define WB_MEM_RANGE_CHECK_EN to add ERR_O and reject addresses beyond DEPTH.
module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int DATA_W      = WB_MEM_DATA_W,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = WB_MEM_DEPTH,
  parameter int WAIT_CYCLES = WB_MEM_WAIT_CYCLES
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [ADDR_W-1:0] ADR_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic              AKN_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [DATA_W-1:0] INSTR_O,
  output logic              BUSY_O
`ifdef WB_MEM_RANGE_CHECK_EN
  ,
  output logic              ERR_O
`endif
);
  localparam int IDX_W = $clog2(DEPTH);

  wb_mem_state_e     state, state_nx;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx_q, in_idx, rd_idx;
  logic              we_q, err_q, in_err, accept, rd_en, wr_en;
  logic [DATA_W-1:0] dat_q, rdata;

  assign in_idx = IDX_W'(wb_mem_idx(64'(ADR_I), IDX_W));
`ifdef WB_MEM_RANGE_CHECK_EN
  assign in_err = (ADR_I >> (IDX_W + 2)) != '0;
`else
  assign in_err = 1'b0;
`endif
  assign accept = (state == IDLE) && STB_I;

  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) state <= IDLE;
    else        state <= state_nx;

  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      cnt   <= '0;
      idx_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      cnt   <= 4'(WAIT_CYCLES);
      idx_q <= in_idx;
      we_q  <= WE_I;
      dat_q <= DAT_I;
      err_q <= in_err;
    end else if (state == WAIT) begin
      cnt   <= cnt - 4'd1;
    end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (STB_I) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // With zero wait states RESP is entered straight from IDLE, so read from the live bus.
    rd_idx  = (state == IDLE) ? in_idx : idx_q;
    rd_en   = (state_nx == RESP) &&
              ((state == IDLE) ? !(WE_I || in_err) : !(we_q || err_q));
    wr_en   = (state == RESP) && we_q && !err_q;
    AKN_O   = (state == RESP) && !err_q;
    BUSY_O  = (state != IDLE);
    DAT_O   = rdata;
    INSTR_O = rdata;
`ifdef WB_MEM_RANGE_CHECK_EN
    ERR_O   = (state == RESP) && err_q;
`endif
  end

  wb_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .we    (wr_en),
    .waddr (idx_q),
    .wdata (dat_q),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_wb_mem_slave.sv
// Randomized bench for wb_mem_slave against a word-array transaction model.
module tb_wb_mem_slave;
  localparam int W = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic        akn, busy;
  logic [31:0] rdat, instr;
  logic        stb0 = 1'b0, we0 = 1'b0;
  logic [31:0] adr0 = '0, wdat0 = '0;
  logic        akn0, busy0;
  logic [31:0] rdat0, instr0;
  logic        err_any;
`ifdef WB_MEM_RANGE_CHECK_EN
  logic        err, err0;
  assign err_any = err;
`else
  assign err_any = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_mem_slave #(.WAIT_CYCLES(W)) dut (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb), .WE_I(we), .ADR_I(adr), .DAT_I(wdat),
    .AKN_O(akn), .DAT_O(rdat), .INSTR_O(instr), .BUSY_O(busy)
`ifdef WB_MEM_RANGE_CHECK_EN
    , .ERR_O(err)
`endif
  );

  wb_mem_slave #(.WAIT_CYCLES(0)) dut0 (
    .CLK_I(clk), .RST_I(rst_n), .STB_I(stb0), .WE_I(we0), .ADR_I(adr0), .DAT_I(wdat0),
    .AKN_O(akn0), .DAT_O(rdat0), .INSTR_O(instr0), .BUSY_O(busy0)
`ifdef WB_MEM_RANGE_CHECK_EN
    , .ERR_O(err0)
`endif
  );

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] last_rd = '0;
  logic [31:0] d0 [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One complete transfer on the W=2 instance, checked against the model.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d);
    int lat;
    bit e, done;
    int unsigned ix;
    e = 1'b0;
`ifdef WB_MEM_RANGE_CHECK_EN
    e = (a >> 12) != 0;
`endif
    ix = (a >> 2) % 1024;
    @(negedge clk);
    chk("akn_idle", 32'(akn), 32'd0);
    stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk);
    #1;
    // bus noise while the transfer is in flight must be ignored
    stb = 1'($urandom); we = 1'($urandom); adr = $urandom; wdat = $urandom;
    lat = 0; done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy", 32'(busy), 32'd1);
      if (akn || err_any) done = 1'b1;
    end
    stb = 1'b0;
    chk("latency", 32'(lat), 32'(W + 1));
    chk("akn", 32'(akn), 32'(!e));
`ifdef WB_MEM_RANGE_CHECK_EN
    chk("err", 32'(err), 32'(e));
`endif
    if (!w && !e) last_rd = ref_mem[ix];
    if (w && !e)  ref_mem[ix] = d;
    chk("dat", rdat, last_rd);
    chk("instr", instr, last_rd);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_akn", 32'(akn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_akn0", 32'(akn0), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) xfer(1'b1, 32'(i * 4), $urandom);

    // zero wait states, STB held high: 4 writes then 4 reads, AKN every other cycle
    for (int k = 0; k < 4; k++) d0[k] = $urandom;
    @(negedge clk);
    stb0 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      we0 = (j < 4); adr0 = 32'((j % 4) * 4); wdat0 = d0[j % 4];
      @(negedge clk);
      chk("w0_akn", 32'(akn0), 32'd1);
      if (j >= 4) begin
        chk("w0_dat", rdat0, d0[j - 4]);
        chk("w0_instr", instr0, d0[j - 4]);
      end
      @(negedge clk);
      chk("w0_gap", 32'(akn0), 32'd0);
    end
    stb0 = 1'b0;

    xfer(1'b1, 32'h10, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 32'h0);
    xfer(1'b1, 32'h22, 32'h12345678);
    xfer(1'b0, 32'h20, 32'h0);
    chk("misalign", rdat, 32'h12345678);
    xfer(1'b0, 32'h1000, 32'h0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = (32'($urandom_range(63)) << 2) | 32'($urandom_range(3));
      if ($urandom_range(3) == 0) a = a | (32'($urandom_range(255, 1)) << 12);
      xfer(1'($urandom), a, $urandom);
    end

    // reset in the middle of a write: no ack, no write, memory preserved
    xfer(1'b1, 32'h40, 32'h0);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 32'h40; wdat = 32'hAAAA5555;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_akn", 32'(akn), 32'd0);
    chk("abort_dat", rdat, 32'd0);
    last_rd = '0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_noakn", 32'(akn), 32'd0);
    end
    rst_n = 1'b1;
    xfer(1'b0, 32'h40, 32'h0);
    chk("abort_mem", rdat, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
